wb_ram_responder: RTL and testbench

Wishbone B4 classic-cycle responder that backs a single-port word-addressed RAM. It is the data-side counterpart to the instruction fetch initiator: the MEM stage's load/store unit, or any other Wishbone initiator, issues cycles that this block accepts, waits on, and terminates. It supports byte-lane writes, a programmable number of wait states, and error termination. Exactly one transaction is in flight at a time.

---
 rtl/wb_ram_responder.sv | 129 ++++++++++++
 tb/tb_wb_ram_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_responder.sv
// Wishbone B4 classic-cycle responder in front of a byte-lane, word-addressed single-port RAM.
// Define WB_RAM_ERR_EN to terminate misaligned or out-of-range requests with oErr instead of aliasing.
module wb_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iCyc,
    input  logic        iStb,
    input  logic        iWe,
    input  logic [31:0] iAddr,
    input  logic [3:0]  iSel,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oAck,
    output logic        oErr,
    output logic        oStall
);
    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = WAIT_STATES[3:0];

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_ack;
    logic           r_err;
    logic           r_we;
    logic [3:0]     r_sel;
    logic [31:0]    r_wdata;
    logic [AW-1:0]  r_idx;
    logic           r_bad;

    logic           w_req;
    logic [31:0]    w_offset;
    logic           w_bad;
    logic           w_mem_en;
    logic [31:0]    w_rd_word;

    assign w_req    = iCyc & iStb;
    assign w_offset = iAddr - BASE_ADDR;

`ifdef WB_RAM_ERR_EN
    // BASE_ADDR is aligned, so the low offset bits equal iAddr[1:0]; addresses below BASE wrap high.
    assign w_bad = (w_offset[1:0] != 2'b00) || (w_offset[31:AW+2] != '0);
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_offset[31:AW+2], w_offset[1:0]};
    assign w_bad         = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_cnt   <= WS;
                        r_state <= (WS != 4'd0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    // An initiator dropping the cycle abandons the request silently.
                    if (!iCyc) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ack   <= !r_bad;
                    r_err   <= r_bad;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (r_state == S_IDLE && w_req) begin
            r_we    <= iWe;
            r_sel   <= iSel;
            r_wdata <= iData;
            r_idx   <= w_offset[AW+1:2];
            r_bad   <= w_bad;
        end
    end

    // Memory is touched only in RESP, so aborts and resets before then leave it untouched.
    assign w_mem_en = (r_state == S_RESP) && !iRst && !r_bad;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd_byte;

            always_ff @(posedge iClk) begin
                if (w_mem_en) begin
                    if (r_we && r_sel[gi]) begin
                        r_mem[r_idx] <= r_wdata[8*gi +: 8];
                    end
                    r_rd_byte <= r_mem[r_idx];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd_byte;
        end
    endgenerate

    assign oData  = r_ack ? w_rd_word : 32'h0;
    assign oAck   = r_ack;
    assign oErr   = r_err;
    assign oStall = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench: four responders with WAIT_STATES 0..3 share one bus; each scenario checks one of them.
module tb_wb_ram_responder;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [31:0]   addr;
    logic [3:0]    sel;
    logic [31:0]   wdata;
    logic [31:0]   rdat [N];
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [N-1:0]  stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        wb_ram_responder #(
            .DEPTH_WORDS(16),
            .BASE_ADDR  (32'h0000_0000),
            .WAIT_STATES(gi)
        ) u_dut (
            .iClk  (clk),
            .iRst  (rst),
            .iCyc  (cyc),
            .iStb  (stb),
            .iWe   (we),
            .iAddr (addr),
            .iSel  (sel),
            .iData (wdata),
            .oData (rdat[gi]),
            .oAck  (ack[gi]),
            .oErr  (err[gi]),
            .oStall(stall[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (stall == '0) break;
            @(negedge clk);
        end
        check("idle", {28'b0, stall}, 32'h0);
    endtask

    // One request, single-cycle strobe; returns termination data, latency and stall cycles for instance d.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output int stalls, output logic e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = wd;
        @(posedge clk);
        #1 stb = 1'b0;
        @(negedge clk);
        lat = -1; stalls = 0; rd = '0; e = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (stall[d]) stalls++;
            if (ack[d] || err[d]) begin
                lat = k; rd = rdat[d]; e = err[d];
                break;
            end
            @(negedge clk);
        end
        $display("[TB] ws=%0d %s addr=0x%08h sel=%h wdata=0x%08h -> data=0x%08h lat=%0d err=%0b",
                 d, w ? "WR" : "RD", a, s, wd, rd, lat, e);
        @(negedge clk);
        check("pulse_width", {31'b0, ack[d] | err[d]}, 32'h0);
        wait_idle();
    endtask

    logic [31:0] rd;
    int          lat;
    int          stalls;
    logic        e;
    logic        seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack",   {31'b0, ack[1]},   32'h0);
        check("rst_err",   {31'b0, err[1]},   32'h0);
        check("rst_stall", {31'b0, stall[1]}, 32'h0);
        check("rst_data",  rdat[1],           32'h0);
        cyc = 1'b1;

        // Byte lanes, WAIT_STATES=1
        xfer(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat, stalls, e);
        check("wr_lat", lat, 32'd2);
        check("wr_stall", stalls, 32'd2);
        check("wr_err", {31'b0, e}, 32'h0);
        xfer(1, 1'b1, 32'h10, 4'h1, 32'h000000AA, rd, lat, stalls, e);
        check("wr1_lat", lat, 32'd2);
        xfer(1, 1'b0, 32'h10, 4'h0, 32'h0, rd, lat, stalls, e);
        check("rd_lane0", rd, 32'hDEADBEAA);
        check("rd_lat", lat, 32'd2);
        check("rd_stall", stalls, 32'd2);
        xfer(1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, rd, lat, stalls, e);
        check("sel0_lat", lat, 32'd2);
        check("sel0_err", {31'b0, e}, 32'h0);
        xfer(1, 1'b1, 32'h10, 4'h6, 32'h11223344, rd, lat, stalls, e);
        xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, stalls, e);
        check("rd_mid_lanes", rd, 32'hDE2233AA);

        // Zero wait states, back-to-back reads
        xfer(0, 1'b1, 32'h0, 4'hF, 32'h01020304, rd, lat, stalls, e);
        check("ws0_lat", lat, 32'd1);
        check("ws0_stall", stalls, 32'd1);
        xfer(0, 1'b1, 32'h4, 4'hF, 32'h05060708, rd, lat, stalls, e);
        @(negedge clk);
        we = 1'b0; addr = 32'h0; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        @(negedge clk);
        check("b2b_stall_a", {31'b0, stall[0]}, 32'h1);
        check("b2b_noack_a", {31'b0, ack[0]}, 32'h0);
        @(negedge clk);
        check("b2b_ack_a", {31'b0, ack[0]}, 32'h1);
        check("b2b_data_a", rdat[0], 32'h01020304);
        check("b2b_idle_a", {31'b0, stall[0]}, 32'h0);
        addr = 32'h4; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        @(negedge clk);
        check("b2b_stall_b", {31'b0, stall[0]}, 32'h1);
        check("b2b_noack_b", {31'b0, ack[0]}, 32'h0);
        @(negedge clk);
        check("b2b_ack_b", {31'b0, ack[0]}, 32'h1);
        check("b2b_data_b", rdat[0], 32'h05060708);
        $display("[TB] ws=0 back-to-back reads 0x0,0x4 done");
        wait_idle();

        // Abort in the second WAIT cycle, WAIT_STATES=3
        xfer(3, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, rd, lat, stalls, e);
        check("ws3_lat", lat, 32'd4);
        check("ws3_stall", stalls, 32'd4);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wait", {31'b0, stall[3]}, 32'h1);
        cyc = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        check("abort_idle", {31'b0, stall[3]}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            seen = seen | ack[3] | err[3];
            @(negedge clk);
        end
        check("abort_no_term", {31'b0, seen}, 32'h0);
        $display("[TB] ws=3 WR addr=0x00000020 aborted");
        cyc = 1'b1;
        wait_idle();
        xfer(3, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat, stalls, e);
        check("abort_keeps_data", rd, 32'hCAFEF00D);

        // Reset one cycle after acceptance, WAIT_STATES=2
        xfer(2, 1'b1, 32'h8, 4'hF, 32'h55AA55AA, rd, lat, stalls, e);
        check("ws2_lat", lat, 32'd3);
        @(negedge clk);
        we = 1'b1; addr = 32'h8; sel = 4'hF; wdata = 32'h0BADCAFE; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", {31'b0, stall[2]}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            seen = seen | ack[2] | err[2];
            @(negedge clk);
        end
        check("rst_mid_no_term", {31'b0, seen}, 32'h0);
        $display("[TB] ws=2 WR addr=0x00000008 dropped by reset");
        xfer(2, 1'b0, 32'h8, 4'hF, 32'h0, rd, lat, stalls, e);
        check("rst_mid_old_data", rd, 32'h55AA55AA);

        // Misaligned / out-of-range handling, WAIT_STATES=1, 16-word RAM
`ifdef WB_RAM_ERR_EN
        xfer(1, 1'b0, 32'h11, 4'hF, 32'h0, rd, lat, stalls, e);
        check("misalign_err", {31'b0, e}, 32'h1);
        check("misalign_data", rd, 32'h0);
        check("misalign_lat", lat, 32'd2);
        xfer(1, 1'b1, 32'h40, 4'hF, 32'h77777777, rd, lat, stalls, e);
        check("oor_err", {31'b0, e}, 32'h1);
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat, stalls, e);
        check("oor_word0", rd, 32'h01020304);
        check("oor_rd_err", {31'b0, e}, 32'h0);
`else
        xfer(1, 1'b0, 32'h11, 4'hF, 32'h0, rd, lat, stalls, e);
        check("misalign_err", {31'b0, e}, 32'h0);
        check("misalign_data", rd, 32'hDE2233AA);
        xfer(1, 1'b1, 32'h40, 4'hF, 32'h77777777, rd, lat, stalls, e);
        check("oor_err", {31'b0, e}, 32'h0);
        check("oor_lat", lat, 32'd2);
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, rd, lat, stalls, e);
        check("oor_word0", rd, 32'h77777777);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
